mem_initiator: RTL
==================

Name: mem_initiator

Overview:
Bus-side master for the 512x32 asynchronous RAM. It accepts single-word load/store requests from the control unit and drives the RAM's read, write, address and write-data lines with safe setup and hold timing. For loads, it captures the RAM's read data into a registered output for the MDR.
It sits between the control unit / MAR / MDR and the RAM, and is the only driver of the RAM control lines.

Parameters:
ADDR_W, 9, RAM address width (512 words)
DATA_W, 32, data word width
RD_WAIT, 1, cycles mem_read is held before capture (>=1)
WR_HOLD, 1, cycles mem_write is held asserted (>=1)

Ports:
clk  in  1  system clock, all state updates on rising edge
clr  in  1  reset, synchronous, active-low
req_read  in  1  load request from control unit, sampled only in IDLE
req_write  in  1  store request from control unit, sampled only in IDLE
addr_in  in  ADDR_W  word address (from MAR), latched on accept
wdata_in  in  DATA_W  store data (from MDR/bus), latched on accept
busy  out  1  high from the cycle after accept until DONE completes
done  out  1  one-cycle pulse on completion
err  out  1  one-cycle pulse: req_read and req_write both high in IDLE
rdata_out  out  DATA_W  registered load result, held until the next load completes
mem_read  out  1  RAM read strobe
mem_write  out  1  RAM write strobe
mem_address  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data; high-Z when not reading

Behaviour:
- Reset (clr==0 at an edge): state=IDLE; all outputs go to 0, including rdata_out, mem_address and mem_wdata. Reset overrides every state, including mid-access; the strobes drop on that same edge.
- FSM states: IDLE, RD_ACTIVE, WR_SETUP, WR_PULSE, WR_RELEASE, DONE. A counter (width clog2 of max(RD_WAIT,WR_HOLD)+1) times RD_ACTIVE and WR_PULSE.
- IDLE transitions:
  - req_read only: latch addr_in, go to RD_ACTIVE.
  - req_write only: latch addr_in and wdata_in, go to WR_SETUP.
  - Both requests high: no access, err=1 for one cycle, stay in IDLE.
  - Neither request: stay in IDLE.
- RD_ACTIVE: mem_read=1 and mem_address=latched address for exactly RD_WAIT cycles. On the last cycle's edge, rdata_out<=mem_rdata, then go to DONE.
- WR_SETUP (1 cycle): mem_address and mem_wdata driven, mem_write=0.
- WR_PULSE: mem_write=1 for exactly WR_HOLD cycles; address and data are unchanged.
- WR_RELEASE (1 cycle): mem_write=0; address and data still held.
- DONE (1 cycle): done=1, strobes 0, return to IDLE. A new request can be accepted in the following IDLE cycle.
- Latency from the accept edge to the done pulse:
  - Load: RD_WAIT+1 cycles (RD_WAIT=1 gives 2).
  - Store: WR_HOLD+3 cycles (WR_HOLD=1 gives 4).
- busy=1 in every state except IDLE. Requests arriving while busy are ignored; they are not queued.
- Invariants:
  - mem_read and mem_write are never both 1.
  - mem_address and mem_wdata change only while mem_write==0. The RAM writes combinationally while its write input is high, so glitch-free addressing is mandatory.
  - All outputs are registered; there are no combinational paths from req_* to mem_*.
- Between accesses, mem_address and mem_wdata hold their last values (not Z).
- rdata_out is not modified by stores, errors or idle cycles.
- Address wrap: none. The full 0..511 range is legal; address 511 needs no special handling.

Decomposition:
- Shared package mem_if_pkg:
  - ADDR_W and DATA_W constants.
  - State enum typedef (IDLE, RD_ACTIVE, WR_SETUP, WR_PULSE, WR_RELEASE, DONE).
  - A MEM_OP typedef (READ, WRITE).
- No sub-module. The FSM and counter are a single flat block. The bench instantiates the existing RAM as the responder.

Test Plan:
- Store, then load: store 0xDEADBEEF to 0x1A5, then load 0x1A5.
  - Store: mem_write high for exactly 1 cycle with mem_address=0x1A5, done 4 cycles after accept.
  - Load: rdata_out=0xDEADBEEF, done 2 cycles after accept.
- Strobe timing check, RD_WAIT=3 and WR_HOLD=2: store then load at address 0x000.
  - mem_write high for 2 cycles, mem_read high for 3 cycles.
  - mem_address never changes while mem_write=1.
  - mem_read and mem_write never both 1.
- Simultaneous request: req_read=req_write=1 in IDLE.
  - err pulses 1 cycle, busy stays 0, no strobe asserted, rdata_out unchanged.
- Request while busy: assert req_write (addr 0x005, data 0x12345678) during a load in progress.
  - Request ignored, RAM[0x005] unchanged, only one done pulse.
- Reset mid-operation: drive clr=0 during WR_PULSE.
  - Next edge: mem_write=0, busy=0, rdata_out=0, state IDLE, no done pulse.
  - A subsequent load of 0x1FF returns the value preloaded in RAM at 0x1FF.

Source files
------------

// File: rtl/mem_initiator_pkg.sv
// Shared types and widths for the RAM bus initiator and its interface.
package mem_if_pkg;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    RD_ACTIVE,
    WR_SETUP,
    WR_PULSE,
    WR_RELEASE,
    DONE
  } state_e;

  typedef enum logic {
    READ,
    WRITE
  } mem_op_e;

endpackage

// File: rtl/mem_initiator_if.sv
// RAM-side bus: strobes, address and data between the initiator and the 512x32 RAM.
interface mem_initiator_if #(
  parameter int unsigned ADDR_W = mem_if_pkg::ADDR_W,
  parameter int unsigned DATA_W = mem_if_pkg::DATA_W
);

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_read,
    output mem_write,
    output mem_address,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  mem_address,
    input  mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mem_initiator.sv
// Single-word load/store master for the asynchronous RAM; every output is registered
// so address/data are stable around the write strobe.
module mem_initiator #(
  parameter int unsigned ADDR_W  = mem_if_pkg::ADDR_W,
  parameter int unsigned DATA_W  = mem_if_pkg::DATA_W,
  parameter int unsigned RD_WAIT = 1,
  parameter int unsigned WR_HOLD = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata_out,
  mem_initiator_if.master   bus
);

  import mem_if_pkg::*;

  localparam int unsigned MAX_WAIT = (RD_WAIT > WR_HOLD) ? RD_WAIT : WR_HOLD;
  localparam int unsigned CNT_W    = $clog2(MAX_WAIT + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;

  // State and output registers; reset clears everything, strobes included.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  // Next state; outputs are decoded from the next state so they align with it after the edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_read && req_write) begin
          err_d = 1'b1;
        end else if (req_read) begin
          addr_d  = addr_in;
          cnt_d   = CNT_W'(RD_WAIT - 1);
          state_d = RD_ACTIVE;
        end else if (req_write) begin
          addr_d  = addr_in;
          wdata_d = wdata_in;
          state_d = WR_SETUP;
        end
      end
      RD_ACTIVE: begin
        if (cnt_q == '0) begin
          rdata_d = bus.mem_rdata;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WR_SETUP: begin
        cnt_d   = CNT_W'(WR_HOLD - 1);
        state_d = WR_PULSE;
      end
      WR_PULSE: begin
        if (cnt_q == '0) begin
          state_d = WR_RELEASE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WR_RELEASE: state_d = DONE;
      DONE:       state_d = IDLE;
      default:    state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    rd_d   = (state_d == RD_ACTIVE);
    wr_d   = (state_d == WR_PULSE);
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign err             = err_q;
  assign rdata_out       = rdata_q;
  assign bus.mem_read    = rd_q;
  assign bus.mem_write   = wr_q;
  assign bus.mem_address = addr_q;
  assign bus.mem_wdata   = wdata_q;

endmodule
